// File: rtl/evo_circuit_tester_if.sv
// Bundle between the evaluation controller, the tester, and one evolved circuit instance.
// The master side is the controller/circuit environment; the slave side is the tester.
interface evo_circuit_tester_if;
  logic        start;
  logic [15:0] expected;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [15:0] unstable;
  logic        pass;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, truth_table, unstable, pass
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, truth_table, unstable, pass
  );
endinterface

// File: rtl/evo_circuit_tester.sv
// Steps an evolved 4-in/1-out circuit through all 16 vectors and measures its truth table.
// Optional macro TESTER_STABILITY_EN: multi-cycle sampling window with per-vector instability flags.
//
// state    | meaning
// S_IDLE   | waiting for start; results held
// S_SETTLE | vector applied, waiting SETTLE_CYCLES for the circuit and synchronizer
// S_SAMPLE | sampling the synchronized output
// S_FINISH | done pulse cycle; busy already low
module evo_circuit_tester #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  evo_circuit_tester_if.slave if_tst
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  localparam logic [7:0] C_SETTLE_LD = 8'(SETTLE_CYCLES - 1);
`ifdef TESTER_STABILITY_EN
  localparam logic [7:0] C_SAMPLE_LD = 8'(SAMPLES - 1);
`else
  // Single-cycle sample window; SAMPLES is accepted but has no effect here.
  localparam logic [7:0] C_SAMPLE_LD = 8'(SAMPLES) & 8'h00;
`endif

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_cnt;
  logic [3:0]  r_vec;
  logic [15:0] r_expected;
  logic [15:0] r_tt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
`ifdef TESTER_STABILITY_EN
  logic [15:0] r_unst;
`endif

  logic        w_first;
  logic        w_last;
  logic [15:0] w_tt_nxt;
  logic [15:0] w_unst_nxt;

  assign w_first = (r_cnt == C_SAMPLE_LD);
  assign w_last  = (r_cnt == 8'd0);

  // Next-value tables so pass can be formed from the final sample in the same edge.
  always_comb begin
    w_tt_nxt = r_tt;
`ifdef TESTER_STABILITY_EN
    w_unst_nxt = r_unst;
`else
    w_unst_nxt = 16'h0000;
`endif
    if (r_state == S_SAMPLE) begin
      if (w_first) begin
        w_tt_nxt[r_vec] = r_sync2;
      end
`ifdef TESTER_STABILITY_EN
      else if (r_sync2 != r_tt[r_vec]) begin
        w_unst_nxt[r_vec] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_cnt      <= 8'd0;
      r_vec      <= 4'd0;
      r_expected <= 16'h0000;
      r_tt       <= 16'h0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
`ifdef TESTER_STABILITY_EN
      r_unst     <= 16'h0000;
`endif
    end else begin
      r_sync1 <= if_tst.dut_out;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_tst.start) begin
            r_expected <= if_tst.expected;
            r_tt       <= 16'h0000;
`ifdef TESTER_STABILITY_EN
            r_unst     <= 16'h0000;
`endif
            r_pass     <= 1'b0;
            r_vec      <= 4'd0;
            r_cnt      <= C_SETTLE_LD;
            r_busy     <= 1'b1;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_last) begin
            r_cnt   <= C_SAMPLE_LD;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          r_tt <= w_tt_nxt;
`ifdef TESTER_STABILITY_EN
          r_unst <= w_unst_nxt;
`endif
          if (w_last) begin
            if (r_vec == 4'hF) begin
              r_pass  <= (w_tt_nxt == r_expected) && (w_unst_nxt == 16'h0000);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_vec   <= r_vec + 4'd1;
              r_cnt   <= C_SETTLE_LD;
              r_state <= S_SETTLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_tst.dut_in      = r_vec;
  assign if_tst.busy        = r_busy;
  assign if_tst.done        = r_done;
  assign if_tst.truth_table = r_tt;
  assign if_tst.pass        = r_pass;
`ifdef TESTER_STABILITY_EN
  assign if_tst.unstable    = r_unst;
`else
  assign if_tst.unstable    = 16'h0000;
`endif

endmodule

// File: tb/tb_evo_circuit_tester.sv
// Self-checking bench for evo_circuit_tester: randomized circuit functions against a
// timing-level reference model that records the circuit output every cycle.
module tb_evo_circuit_tester;
  localparam int S  = 16;
  localparam int N  = 8;
`ifdef TESTER_STABILITY_EN
  localparam int NE = N;
`else
  localparam int NE = 1;
`endif
  localparam int VEC_CYC = S + NE;
  localparam int DONE_AT = 1 + 16 * VEC_CYC;
  localparam int S2 = 3;
  localparam int N2 = 1;
  localparam int DONE2 = 1 + 16 * (S2 + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  evo_circuit_tester_if if_a ();
  evo_circuit_tester_if if_b ();

  evo_circuit_tester #(.SETTLE_CYCLES(S), .SAMPLES(N)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .if_tst(if_a));
  evo_circuit_tester #(.SETTLE_CYCLES(S2), .SAMPLES(N2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .if_tst(if_b));

  logic [15:0] func_a = 16'h0000;
  logic        toggle_mode = 1'b0;
  logic        r_tog = 1'b0;
  always @(posedge clk) r_tog <= ~r_tog;

  assign if_a.dut_out = (toggle_mode && if_a.dut_in == 4'd5) ? r_tog : func_a[if_a.dut_in];
  assign if_b.dut_out = &if_b.dut_in;

  logic hist [0:16383];
  always @(negedge clk) hist[cyc & 16383] = if_a.dut_out;

  // Sample j of vector v happens in cycle c0+1+v*VEC_CYC+S+j and sees the output two cycles earlier.
  function automatic void model_run(input int c0, input logic [15:0] exp,
                                    output logic [15:0] tt, output logic [15:0] un,
                                    output logic ps);
    tt = 16'h0000;
    un = 16'h0000;
    for (int v = 0; v < 16; v++) begin
      int   base;
      logic first;
      base  = c0 + 1 + v * VEC_CYC + S;
      first = hist[(base - 2) & 16383];
      tt[v] = first;
      for (int j = 1; j < NE; j++)
        if (hist[(base + j - 2) & 16383] !== first) un[v] = 1'b1;
    end
    ps = (tt == exp) && (un == 16'h0000);
  endfunction

  task automatic do_run(input logic [15:0] exp, input int pulse_at, input logic [15:0] exp2,
                        output int c0, output int done_rel, output logic busy1,
                        output logic [3:0] din1, output logic busy_at_done);
    @(negedge clk);
    if_a.start = 1'b1;
    if_a.expected = exp;
    c0 = cyc;
    @(negedge clk);
    if_a.start = 1'b0;
    busy1 = if_a.busy;
    din1 = if_a.dut_in;
    done_rel = -1;
    busy_at_done = 1'bx;
    for (int k = 2; k < 3000 && done_rel < 0; k++) begin
      @(negedge clk);
      if (pulse_at > 0 && cyc == c0 + pulse_at) begin
        if_a.start = 1'b1;
        if_a.expected = exp2;
      end else begin
        if_a.start = 1'b0;
      end
      if (if_a.done) begin
        done_rel = cyc - c0;
        busy_at_done = if_a.busy;
      end
    end
    if_a.start = 1'b0;
    n_checks++;
    if (done_rel < 0) begin
      n_fail++;
      $display("FAIL run_timeout: done never seen, required at cycle %0d", DONE_AT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.start = 1'b0; if_a.expected = 16'h0000;
    if_b.start = 1'b0; if_b.expected = 16'h0000;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (if_a.dut_in !== 4'h0) begin n_fail++; $display("FAIL reset_dut_in: got %h want 0", if_a.dut_in); end
    if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
    if (if_a.truth_table !== 16'h0) begin n_fail++; $display("FAIL reset_tt: got %h want 0", if_a.truth_table); end
    if (if_a.unstable !== 16'h0) begin n_fail++; $display("FAIL reset_unstable: got %h want 0", if_a.unstable); end
    if (if_a.pass !== 1'b0 || if_b.pass !== 1'b0 || if_b.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_pass_b: got pass %b/%b busy_b %b want 0", if_a.pass, if_b.pass, if_b.busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_xor();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun;
    func_a = 16'h6996; toggle_mode = 1'b0;
    do_run(16'h6996, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'h6996, mtt, mun, mps);
    n_checks += 8;
    if (dr !== DONE_AT) begin n_fail++; $display("FAIL xor_done_cycle: got %0d want %0d", dr, DONE_AT); end
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL xor_busy_c1: got %b want 1", b1); end
    if (d1 !== 4'h0) begin n_fail++; $display("FAIL xor_dut_in_c1: got %h want 0", d1); end
    if (bd !== 1'b0) begin n_fail++; $display("FAIL xor_busy_at_done: got %b want 0", bd); end
    if (if_a.truth_table !== mtt || mtt !== 16'h6996) begin
      n_fail++; $display("FAIL xor_tt: got %h want %h", if_a.truth_table, mtt);
    end
    if (if_a.unstable !== mun) begin n_fail++; $display("FAIL xor_unstable: got %h want %h", if_a.unstable, mun); end
    if (if_a.pass !== 1'b1) begin n_fail++; $display("FAIL xor_pass: got %b want 1", if_a.pass); end
    repeat (5) @(negedge clk);
    if (if_a.dut_in !== 4'hF || if_a.pass !== mps || if_a.done !== 1'b0) begin
      n_fail++; $display("FAIL xor_hold: got dut_in %h pass %b done %b want F %b 0", if_a.dut_in, if_a.pass, if_a.done, mps);
    end
  endtask

  task automatic test_stuck();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun;
    func_a = 16'hFFFF; toggle_mode = 1'b0;
    do_run(16'h6996, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'h6996, mtt, mun, mps);
    n_checks += 5;
    if (d1 !== 4'h0) begin n_fail++; $display("FAIL stuck_dut_in_c1: got %h want 0", d1); end
    if (if_a.truth_table !== 16'hFFFF) begin n_fail++; $display("FAIL stuck_tt: got %h want FFFF", if_a.truth_table); end
    if (if_a.unstable !== 16'h0000) begin n_fail++; $display("FAIL stuck_unstable: got %h want 0", if_a.unstable); end
    if (if_a.pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %b want 0", if_a.pass); end
    if (if_a.pass !== mps || if_a.truth_table !== mtt) begin
      n_fail++; $display("FAIL stuck_model: got %h/%b want %h/%b", if_a.truth_table, if_a.pass, mtt, mps);
    end
  endtask

  task automatic test_toggle();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun, want_un;
`ifdef TESTER_STABILITY_EN
    want_un = 16'h0020;
`else
    want_un = 16'h0000;
`endif
    func_a = 16'h0020; toggle_mode = 1'b1;
    do_run(16'h0020, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'h0020, mtt, mun, mps);
    toggle_mode = 1'b0;
    n_checks += 5;
    if (dr !== DONE_AT) begin n_fail++; $display("FAIL toggle_done_cycle: got %0d want %0d", dr, DONE_AT); end
    if (if_a.unstable !== want_un) begin n_fail++; $display("FAIL toggle_unstable: got %h want %h", if_a.unstable, want_un); end
    if (if_a.unstable !== mun) begin n_fail++; $display("FAIL toggle_unstable_model: got %h want %h", if_a.unstable, mun); end
    if ((if_a.truth_table & 16'hFFDF) !== 16'h0000 || if_a.truth_table !== mtt) begin
      n_fail++; $display("FAIL toggle_tt: got %h want %h", if_a.truth_table, mtt);
    end
    if (if_a.pass !== mps) begin n_fail++; $display("FAIL toggle_pass: got %b want %b", if_a.pass, mps); end
  endtask

  task automatic test_start_ignored();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun;
    func_a = 16'h6996; toggle_mode = 1'b0;
    do_run(16'h6996, 100, 16'h1234, c0, dr, b1, d1, bd);
    model_run(c0, 16'h6996, mtt, mun, mps);
    n_checks += 3;
    if (dr !== DONE_AT) begin n_fail++; $display("FAIL ignored_done_cycle: got %0d want %0d", dr, DONE_AT); end
    if (if_a.pass !== 1'b1 || mps !== 1'b1) begin n_fail++; $display("FAIL ignored_pass: got %b want 1", if_a.pass); end
    if (if_a.truth_table !== mtt) begin n_fail++; $display("FAIL ignored_tt: got %h want %h", if_a.truth_table, mtt); end
  endtask

  task automatic test_reset_midrun();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun;
    func_a = 16'h3C5A; toggle_mode = 1'b0;
    @(negedge clk);
    if_a.start = 1'b1; if_a.expected = 16'h3C5A; c0 = cyc;
    @(negedge clk);
    if_a.start = 1'b0;
    for (int k = 0; k < 400 && cyc < c0 + 200; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (if_a.dut_in !== 4'h0 || if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got dut_in %h busy %b done %b want 0 0 0", if_a.dut_in, if_a.busy, if_a.done);
    end
    if (if_a.truth_table !== 16'h0 || if_a.unstable !== 16'h0 || if_a.pass !== 1'b0) begin
      n_fail++; $display("FAIL midrst_results: got tt %h un %h pass %b want 0", if_a.truth_table, if_a.unstable, if_a.pass);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_run(16'h3C5A, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'h3C5A, mtt, mun, mps);
    n_checks += 2;
    if (dr !== DONE_AT) begin n_fail++; $display("FAIL midrst_done_cycle: got %0d want %0d", dr, DONE_AT); end
    if (if_a.truth_table !== mtt || if_a.pass !== mps || mps !== 1'b1) begin
      n_fail++; $display("FAIL midrst_result: got %h/%b want %h/%b", if_a.truth_table, if_a.pass, mtt, mps);
    end
  endtask

  task automatic test_back_to_back();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun;
    func_a = 16'h0F0F; toggle_mode = 1'b0;
    do_run(16'h0F0F, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'h0F0F, mtt, mun, mps);
    if_a.start = 1'b1; if_a.expected = 16'hAAAA;
    @(negedge clk);
    if_a.start = 1'b0;
    n_checks += 2;
    if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done: got busy %b want 0", if_a.busy); end
    repeat (3) @(negedge clk);
    if (if_a.pass !== mps || if_a.truth_table !== mtt || if_a.dut_in !== 4'hF) begin
      n_fail++; $display("FAIL b2b_hold: got %h/%b/%h want %h/%b/F", if_a.truth_table, if_a.pass, if_a.dut_in, mtt, mps);
    end
    func_a = 16'hAAAA;
    do_run(16'hAAAA, 0, 16'h0000, c0, dr, b1, d1, bd);
    model_run(c0, 16'hAAAA, mtt, mun, mps);
    n_checks += 3;
    if (dr !== DONE_AT) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", dr, DONE_AT); end
    if (d1 !== 4'h0 || b1 !== 1'b1) begin n_fail++; $display("FAIL b2b_c1: got dut_in %h busy %b want 0 1", d1, b1); end
    if (if_a.truth_table !== mtt || if_a.pass !== mps) begin
      n_fail++; $display("FAIL b2b_result: got %h/%b want %h/%b", if_a.truth_table, if_a.pass, mtt, mps);
    end
  endtask

  task automatic test_random();
    int c0, dr; logic b1, bd, mps; logic [3:0] d1; logic [15:0] mtt, mun, exp;
    for (int r = 0; r < 4; r++) begin
      func_a = 16'($urandom);
      toggle_mode = ($urandom_range(0, 3) == 0);
      exp = ($urandom_range(0, 1) == 1) ? func_a : 16'($urandom);
      do_run(exp, 0, 16'h0000, c0, dr, b1, d1, bd);
      model_run(c0, exp, mtt, mun, mps);
      n_checks += 3;
      if (dr !== DONE_AT) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", r, dr, DONE_AT); end
      if (if_a.truth_table !== mtt || if_a.unstable !== mun) begin
        n_fail++; $display("FAIL rand%0d_table: got %h/%h want %h/%h", r, if_a.truth_table, if_a.unstable, mtt, mun);
      end
      if (if_a.pass !== mps) begin n_fail++; $display("FAIL rand%0d_pass: got %b want %b", r, if_a.pass, mps); end
    end
    toggle_mode = 1'b0;
  endtask

  task automatic test_small();
    int c0, dr; logic [15:0] want_tt;
    want_tt = 16'h0000;
    for (int v = 0; v < 16; v++) want_tt[v] = (v == 15);
    @(negedge clk);
    if_b.start = 1'b1; if_b.expected = 16'h8000; c0 = cyc;
    @(negedge clk);
    if_b.start = 1'b0;
    dr = -1;
    for (int k = 2; k < 500 && dr < 0; k++) begin
      @(negedge clk);
      if (if_b.done) dr = cyc - c0;
    end
    n_checks += 4;
    if (dr !== DONE2) begin n_fail++; $display("FAIL small_done_cycle: got %0d want %0d", dr, DONE2); end
    if (if_b.truth_table !== want_tt) begin n_fail++; $display("FAIL small_tt: got %h want %h", if_b.truth_table, want_tt); end
    if (if_b.unstable !== 16'h0000) begin n_fail++; $display("FAIL small_unstable: got %h want 0", if_b.unstable); end
    if (if_b.pass !== 1'b1) begin n_fail++; $display("FAIL small_pass: got %b want 1", if_b.pass); end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_stuck();
    test_toggle();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
